seq_divider: RTL

Parametrised multi-cycle integer divider for the execute stage, replacing the single-cycle combinational divide path. It computes quotient and remainder of two WIDTH-bit operands in signed or unsigned mode using radix-2 restoring division, one quotient bit per clock. Divide-by-zero and signed overflow follow RISC-V M-extension semantics. A start/busy/done handshake lets the pipeline stall while a division is in flight.

---
 rtl/seq_divider.sv | 109 ++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider, signed/unsigned, RISC-V div-by-zero/overflow results
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_is_signed,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, CALC, FIX, FINISH} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic             w_zero;
  logic             w_ovf;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_sub;
  logic             w_ge;
  // operand magnitudes, special-case detection and one restoring step
  always_comb begin
    w_dvd_neg = i_is_signed & i_dividend[WIDTH-1];
    w_dvs_neg = i_is_signed & i_divisor[WIDTH-1];
    w_dvd_mag = w_dvd_neg ? -i_dividend : i_dividend;
    w_dvs_mag = w_dvs_neg ? -i_divisor : i_divisor;
    w_zero    = i_divisor == '0;
    w_ovf     = i_is_signed && i_dividend == {1'b1, {(WIDTH-1){1'b0}}} && i_divisor == '1;
    w_shift   = {r_acc, r_q[WIDTH-1]};
    w_ge      = w_shift >= {1'b0, r_dvs};
    w_sub     = w_shift[WIDTH-1:0] - r_dvs;
  end
  // control FSM with datapath; special cases route through FIX so they take one busy cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_acc         <= '0;
      r_q           <= '0;
      r_dvs         <= '0;
      r_cnt         <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_dz          <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE, FINISH: begin
          if (i_start) begin
            o_busy <= 1'b1;
            if (w_zero || w_ovf) begin
              r_q     <= w_zero ? '1 : i_dividend;
              r_acc   <= w_zero ? i_dividend : '0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_dz    <= w_zero;
              r_state <= FIX;
            end else begin
              r_q     <= w_dvd_mag;
              r_dvs   <= w_dvs_mag;
              r_acc   <= '0;
              r_cnt   <= CW'(WIDTH);
              r_neg_q <= w_dvd_neg ^ w_dvs_neg;
              r_neg_r <= w_dvd_neg;
              r_dz    <= 1'b0;
              r_state <= CALC;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        CALC: begin
          r_acc <= w_ge ? w_sub : w_shift[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= FIX;
        end
        FIX: begin
          o_quotient    <= r_neg_q ? -r_q : r_q;
          o_remainder   <= r_neg_r ? -r_acc : r_acc;
          o_div_by_zero <= r_dz;
          o_busy        <= 1'b0;
          o_done        <= 1'b1;
          r_state       <= FINISH;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
